// File: rtl/grf_scoreboard_if.sv
// grf_scoreboard_if
//   Bundles the issue-side and writeback-side signals of the register-file
//   scoreboard.
//   master : decode/issue + writeback (drives requests, sees status)
//   slave  : the scoreboard itself
//   Signals:
//     issue_valid/rs/rt/use_rs/use_rt/wr/rd : instruction presented by decode
//     issue_ready, stall                    : issue handshake result
//     wb_valid, wb_rd                       : register write retiring this cycle
//     rs_busy, rt_busy                      : per-source RAW hazard status
//     busy_any                              : any write outstanding
//     err_underflow                         : sticky writeback-without-issue flag
interface grf_scoreboard_if;
  logic       issue_valid;
  logic [4:0] issue_rs;
  logic [4:0] issue_rt;
  logic       issue_use_rs;
  logic       issue_use_rt;
  logic       issue_wr;
  logic [4:0] issue_rd;
  logic       issue_ready;
  logic       stall;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       rs_busy;
  logic       rt_busy;
  logic       busy_any;
  logic       err_underflow;

  modport master (
    output issue_valid, issue_rs, issue_rt, issue_use_rs, issue_use_rt,
           issue_wr, issue_rd, wb_valid, wb_rd,
    input  issue_ready, stall, rs_busy, rt_busy, busy_any, err_underflow
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_use_rs, issue_use_rt,
           issue_wr, issue_rd, wb_valid, wb_rd,
    output issue_ready, stall, rs_busy, rt_busy, busy_any, err_underflow
  );
endinterface

// File: rtl/grf_scoreboard.sv
// grf_scoreboard
//   Counts in-flight writes per architectural register and stalls issue on
//   RAW hazards or when a destination's pending counter would saturate.
//   A write retiring this cycle is treated as already done (mirrors the
//   register file's same-cycle write-to-read bypass).
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous active-low reset
//     sb    : scoreboard interface, slave side
//   Parameters:
//     NREG  : number of registers (<= 32, register 0 is hard-wired zero)
//     CNT_W : width of each pending-write counter
module grf_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  grf_scoreboard_if.slave   sb
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CNT_W-1:0] cnt  [NREG];
  logic [CNT_W-1:0] pend [NREG];
  logic [NREG-1:0]  inc_v;
  logic [NREG-1:0]  dec_v;
  logic             wb_underflow;
  logic             busy_any_c;
  logic             accept;
  logic             waw_full;
  logic             err_q;

  // Writeback side: decrements, underflow detection and effective pending.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    dec_v        = '0;
    wb_underflow = 1'b0;
    busy_any_c   = 1'b0;
    pend[0]      = '0;
    for (int i = 1; i < NREG; i++) begin
      dec_v[i] = sb.wb_valid && (sb.wb_rd == 5'(i)) && (cnt[i] != '0);
      if (sb.wb_valid && (sb.wb_rd == 5'(i)) && (cnt[i] == '0))
        wb_underflow = 1'b1;
      pend[i] = dec_v[i] ? cnt[i] - CNT_ONE : cnt[i];
      if (cnt[i] != '0)
        busy_any_c = 1'b1;
    end
  end

  // Register index -> effective pending count; indices >= NREG and
  // register 0 read as never pending.
  function automatic logic [CNT_W-1:0] pend_at(input logic [4:0] r);
    pend_at = '0;
    for (int i = 1; i < NREG; i++)
      if (r == 5'(i))
        pend_at = pend[i];
  endfunction

  assign sb.rs_busy  = sb.issue_use_rs && (sb.issue_rs != 5'd0) && (pend_at(sb.issue_rs) != '0);
  assign sb.rt_busy  = sb.issue_use_rt && (sb.issue_rt != 5'd0) && (pend_at(sb.issue_rt) != '0);
  assign waw_full    = sb.issue_wr && (sb.issue_rd != 5'd0) && (pend_at(sb.issue_rd) == CNT_MAX);

  assign sb.issue_ready   = ~(sb.rs_busy | sb.rt_busy | waw_full);
  assign sb.stall         = sb.issue_valid & ~sb.issue_ready;
  assign sb.busy_any      = busy_any_c;
  assign sb.err_underflow = err_q;

  // Only an accepted instruction counts its write.
  assign accept = sb.issue_valid & sb.issue_ready;

  always_comb begin
    inc_v = '0;
    for (int i = 1; i < NREG; i++)
      inc_v[i] = accept && sb.issue_wr && (sb.issue_rd == 5'(i));
  end

  // NOTE: the counter array is architectural state that gates issue, so
  // every entry is cleared by the asynchronous reset rather than left
  // uninitialised like a data RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++)
        cnt[i] <= '0;
      err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every counter updates from the
      // pre-edge values the combinational logic was computed from.
      for (int i = 1; i < NREG; i++) begin
        if (inc_v[i] && !dec_v[i])
          cnt[i] <= cnt[i] + CNT_ONE;
        else if (dec_v[i] && !inc_v[i])
          cnt[i] <= cnt[i] - CNT_ONE;
      end
      if (wb_underflow)
        err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_grf_scoreboard.sv
module tb_grf_scoreboard;
  localparam int NREG  = 32;
  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk;
  logic reset;
  grf_scoreboard_if sbif ();

  grf_scoreboard #(.NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sbif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending writes per register as plain integers.
  int mcnt [NREG];
  bit merr;

  function automatic int pend_of(int r);
    if (r == 0) return 0;
    if (sbif.wb_valid && int'(sbif.wb_rd) == r && mcnt[r] > 0) return mcnt[r] - 1;
    return mcnt[r];
  endfunction

  function automatic bit exp_rs_busy();
    return sbif.issue_use_rs && sbif.issue_rs != 0 && pend_of(int'(sbif.issue_rs)) != 0;
  endfunction

  function automatic bit exp_rt_busy();
    return sbif.issue_use_rt && sbif.issue_rt != 0 && pend_of(int'(sbif.issue_rt)) != 0;
  endfunction

  function automatic bit exp_ready();
    bit waw;
    waw = sbif.issue_wr && sbif.issue_rd != 0 && pend_of(int'(sbif.issue_rd)) == MAXC;
    return !(exp_rs_busy() || exp_rt_busy() || waw);
  endfunction

  function automatic bit exp_busy_any();
    for (int r = 0; r < NREG; r++)
      if (mcnt[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) mcnt[r] = 0;
    merr = 1'b0;
  endtask

  task automatic idle();
    sbif.issue_valid  = 1'b0;
    sbif.issue_rs     = 5'd0;
    sbif.issue_rt     = 5'd0;
    sbif.issue_use_rs = 1'b0;
    sbif.issue_use_rt = 1'b0;
    sbif.issue_wr     = 1'b0;
    sbif.issue_rd     = 5'd0;
    sbif.wb_valid     = 1'b0;
    sbif.wb_rd        = 5'd0;
  endtask

  task automatic drive_issue(bit v, int rs, bit urs, int rt, bit urt, bit wr, int rd);
    sbif.issue_valid  = v;
    sbif.issue_rs     = 5'(rs);
    sbif.issue_use_rs = urs;
    sbif.issue_rt     = 5'(rt);
    sbif.issue_use_rt = urt;
    sbif.issue_wr     = wr;
    sbif.issue_rd     = 5'(rd);
  endtask

  task automatic drive_wb(bit v, int rd);
    sbif.wb_valid = v;
    sbif.wb_rd    = 5'(rd);
  endtask

  // Advance one clock edge and update the model with the inputs applied.
  task automatic step();
    bit acc, iwr, wbv, dec;
    int ird, wrd;
    acc = sbif.issue_valid && exp_ready();
    iwr = sbif.issue_wr;
    ird = int'(sbif.issue_rd);
    wbv = sbif.wb_valid;
    wrd = int'(sbif.wb_rd);
    @(posedge clk);
    if (!reset) begin
      model_clear();
    end else begin
      dec = 1'b0;
      if (wbv && wrd != 0) begin
        if (mcnt[wrd] > 0) dec = 1'b1;
        else merr = 1'b1;
      end
      if (acc && iwr && ird != 0) mcnt[ird] = mcnt[ird] + 1;
      if (dec) mcnt[wrd] = mcnt[wrd] - 1;
    end
    #1;
  endtask

  task automatic test_reset();
    drive_issue(1, 5, 1, 6, 1, 1, 7);
    drive_wb(1, 3);
    #1;
    n_vec++; if (sbif.issue_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", sbif.issue_ready); end
    n_vec++; if (sbif.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", sbif.stall); end
    n_vec++; if (sbif.rs_busy !== 1'b0 || sbif.rt_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got rs=%b rt=%b want 0 0", sbif.rs_busy, sbif.rt_busy); end
    n_vec++; if (sbif.busy_any !== 1'b0 || sbif.err_underflow !== 1'b0) begin n_err++; $display("FAIL reset_state: got busy_any=%b err=%b want 0 0", sbif.busy_any, sbif.err_underflow); end
    step();
    step();
    @(negedge clk);
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_raw();
    drive_issue(1, 5, 1, 6, 1, 1, 7);
    @(negedge clk);
    n_vec++; if (sbif.issue_ready !== 1'b1) begin n_err++; $display("FAIL idle_ready: got %b want 1", sbif.issue_ready); end
    n_vec++; if (sbif.busy_any !== 1'b0) begin n_err++; $display("FAIL idle_busy_any: got %b want 0", sbif.busy_any); end
    step();
    drive_issue(1, 7, 1, 0, 0, 0, 0);
    @(negedge clk);
    n_vec++; if (sbif.rs_busy !== 1'b1) begin n_err++; $display("FAIL raw_rs_busy: got %b want 1", sbif.rs_busy); end
    n_vec++; if (sbif.stall !== 1'b1) begin n_err++; $display("FAIL raw_stall: got %b want 1", sbif.stall); end
    n_vec++; if (sbif.busy_any !== 1'b1) begin n_err++; $display("FAIL raw_busy_any: got %b want 1", sbif.busy_any); end
    step();
  endtask

  task automatic test_bypass();
    // cnt[7] is 1 from test_raw.
    drive_issue(1, 7, 1, 0, 0, 0, 0);
    drive_wb(1, 7);
    @(negedge clk);
    n_vec++; if (sbif.rs_busy !== 1'b0) begin n_err++; $display("FAIL bypass_rs_busy: got %b want 0", sbif.rs_busy); end
    n_vec++; if (sbif.issue_ready !== 1'b1) begin n_err++; $display("FAIL bypass_ready: got %b want 1", sbif.issue_ready); end
    step();
    idle();
    drive_issue(1, 7, 1, 7, 1, 0, 0);
    @(negedge clk);
    n_vec++; if (sbif.busy_any !== 1'b0 || sbif.rs_busy !== 1'b0) begin n_err++; $display("FAIL bypass_after: got busy_any=%b rs_busy=%b want 0 0", sbif.busy_any, sbif.rs_busy); end
    step();
    idle();
  endtask

  task automatic test_multi_inflight();
    for (int k = 0; k < 3; k++) begin
      drive_issue(1, 0, 0, 0, 0, 1, 9);
      @(negedge clk);
      n_vec++; if (sbif.issue_ready !== 1'b1) begin n_err++; $display("FAIL multi_ready_%0d: got %b want 1", k, sbif.issue_ready); end
      step();
    end
    drive_issue(1, 0, 0, 0, 0, 1, 9);
    @(negedge clk);
    n_vec++; if (sbif.stall !== 1'b1) begin n_err++; $display("FAIL waw_stall: got %b want 1", sbif.stall); end
    drive_wb(1, 9);
    #1;
    n_vec++; if (sbif.issue_ready !== 1'b1) begin n_err++; $display("FAIL waw_bypass_ready: got %b want 1", sbif.issue_ready); end
    step();
    idle();
    drive_issue(1, 0, 0, 0, 0, 1, 9);
    @(negedge clk);
    n_vec++; if (sbif.stall !== 1'b1) begin n_err++; $display("FAIL waw_still_full: got stall=%b want 1", sbif.stall); end
    idle();
    for (int k = 0; k < 3; k++) begin
      drive_wb(1, 9);
      step();
    end
    idle();
    @(negedge clk);
    n_vec++; if (sbif.busy_any !== 1'b0 || sbif.err_underflow !== 1'b0) begin n_err++; $display("FAIL multi_drain: got busy_any=%b err=%b want 0 0", sbif.busy_any, sbif.err_underflow); end
    step();
  endtask

  task automatic test_reg_zero();
    drive_issue(1, 0, 0, 0, 0, 1, 0);
    step();
    drive_issue(1, 0, 1, 0, 1, 1, 0);
    drive_wb(1, 0);
    @(negedge clk);
    n_vec++; if (sbif.rs_busy !== 1'b0 || sbif.rt_busy !== 1'b0) begin n_err++; $display("FAIL zero_busy: got rs=%b rt=%b want 0 0", sbif.rs_busy, sbif.rt_busy); end
    n_vec++; if (sbif.issue_ready !== 1'b1 || sbif.busy_any !== 1'b0) begin n_err++; $display("FAIL zero_ready: got ready=%b busy_any=%b want 1 0", sbif.issue_ready, sbif.busy_any); end
    step();
    idle();
    @(negedge clk);
    n_vec++; if (sbif.err_underflow !== 1'b0) begin n_err++; $display("FAIL zero_no_err: got %b want 0", sbif.err_underflow); end
    step();
  endtask

  task automatic test_underflow();
    drive_wb(1, 12);
    @(negedge clk);
    n_vec++; if (sbif.err_underflow !== 1'b0) begin n_err++; $display("FAIL underflow_pre: got %b want 0", sbif.err_underflow); end
    step();
    idle();
    @(negedge clk);
    n_vec++; if (sbif.err_underflow !== 1'b1) begin n_err++; $display("FAIL underflow_set: got %b want 1", sbif.err_underflow); end
    repeat (3) step();
    drive_issue(1, 12, 1, 0, 0, 0, 0);
    @(negedge clk);
    n_vec++; if (sbif.err_underflow !== 1'b1) begin n_err++; $display("FAIL underflow_sticky: got %b want 1", sbif.err_underflow); end
    n_vec++; if (sbif.rs_busy !== 1'b0 || sbif.busy_any !== 1'b0) begin n_err++; $display("FAIL underflow_cnt: got rs_busy=%b busy_any=%b want 0 0", sbif.rs_busy, sbif.busy_any); end
    step();
    idle();
  endtask

  task automatic test_reset_mid();
    drive_issue(1, 0, 0, 0, 0, 1, 3); step();
    drive_issue(1, 0, 0, 0, 0, 1, 3); step();
    drive_issue(1, 0, 0, 0, 0, 1, 4); step();
    drive_issue(1, 3, 1, 4, 1, 0, 0);
    @(negedge clk);
    n_vec++; if (sbif.stall !== 1'b1 || sbif.busy_any !== 1'b1) begin n_err++; $display("FAIL mid_pre: got stall=%b busy_any=%b want 1 1", sbif.stall, sbif.busy_any); end
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    n_vec++; if (sbif.rs_busy !== 1'b0 || sbif.rt_busy !== 1'b0 || sbif.busy_any !== 1'b0) begin n_err++; $display("FAIL mid_async_busy: got rs=%b rt=%b any=%b want 0 0 0", sbif.rs_busy, sbif.rt_busy, sbif.busy_any); end
    n_vec++; if (sbif.issue_ready !== 1'b1 || sbif.stall !== 1'b0 || sbif.err_underflow !== 1'b0) begin n_err++; $display("FAIL mid_async_ready: got ready=%b stall=%b err=%b want 1 0 0", sbif.issue_ready, sbif.stall, sbif.err_underflow); end
    step();
    step();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    drive_issue(1, 3, 1, 0, 0, 1, 5);
    @(negedge clk);
    n_vec++; if (sbif.issue_ready !== 1'b1) begin n_err++; $display("FAIL mid_after_ready: got %b want 1", sbif.issue_ready); end
    step();
    idle();
  endtask

  task automatic test_random();
    bit e_rs, e_rt, e_rdy, e_stall, e_any;
    for (int k = 0; k < 1500; k++) begin
      drive_issue($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7));
      drive_wb($urandom_range(0, 1), $urandom_range(0, 7));
      @(negedge clk);
      e_rs    = exp_rs_busy();
      e_rt    = exp_rt_busy();
      e_rdy   = exp_ready();
      e_stall = sbif.issue_valid && !e_rdy;
      e_any   = exp_busy_any();
      n_vec++; if (sbif.rs_busy !== e_rs) begin n_err++; $display("FAIL rand_rs_busy @%0d: got %b want %b", k, sbif.rs_busy, e_rs); end
      n_vec++; if (sbif.rt_busy !== e_rt) begin n_err++; $display("FAIL rand_rt_busy @%0d: got %b want %b", k, sbif.rt_busy, e_rt); end
      n_vec++; if (sbif.issue_ready !== e_rdy) begin n_err++; $display("FAIL rand_ready @%0d: got %b want %b", k, sbif.issue_ready, e_rdy); end
      n_vec++; if (sbif.stall !== e_stall) begin n_err++; $display("FAIL rand_stall @%0d: got %b want %b", k, sbif.stall, e_stall); end
      n_vec++; if (sbif.busy_any !== e_any) begin n_err++; $display("FAIL rand_busy_any @%0d: got %b want %b", k, sbif.busy_any, e_any); end
      n_vec++; if (sbif.err_underflow !== merr) begin n_err++; $display("FAIL rand_err @%0d: got %b want %b", k, sbif.err_underflow, merr); end
      step();
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    model_clear();
    #1;
    reset = 1'b0;
    test_reset();
    test_raw();
    test_bypass();
    test_multi_inflight();
    test_reg_zero();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
